// File: rtl/race_controller_if.sv
// Signal bundle between the race controller, the menu manager and the LED strip driver.
// The controller takes the slave view; the surrounding system (or a bench) takes the master view.
interface race_controller_if;
    logic        is_in_menu;
    logic [3:0]  move;
    logic        refresh_ack;
    logic [1:0]  phase;
    logic [31:0] pos;
    logic [3:0]  winner;
    logic        menu_reset;
    logic        refresh_req;

    modport slave (
        input  is_in_menu, move, refresh_ack,
        output phase, pos, winner, menu_reset, refresh_req
    );

    modport master (
        output is_in_menu, move, refresh_ack,
        input  phase, pos, winner, menu_reset, refresh_req
    );
endinterface

// File: rtl/race_controller.sv
// Four-player LED race: MENU -> RACE -> FINISH (hold) -> RESTART, with a
// dirty-tracking redraw request towards the LED strip driver.
module race_controller #(
    parameter int TRACK_LEN             = 50,
    parameter int FINISH_HOLD_CLK_COUNT = 250000000
) (
    input  logic             clk,
    input  logic             reset,
    race_controller_if.slave rc
);
    typedef enum logic [1:0] {
        MENU    = 2'd0,
        RACE    = 2'd1,
        FINISH  = 2'd2,
        RESTART = 2'd3
    } phase_t;

    localparam int              CNT_W      = (FINISH_HOLD_CLK_COUNT > 1) ? $clog2(FINISH_HOLD_CLK_COUNT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FINISH_HOLD_CLK_COUNT - 1);
    localparam logic [7:0]      TRACK_END  = 8'(TRACK_LEN);

    phase_t          state_q, state_d;
    logic [3:0][7:0] pos_q, pos_d;
    logic [3:0]      winner_q, winner_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]      arrived;
    logic            menu_q;
    logic            menu_seen_q;
    logic            menu_reset_q;
    logic            dirty_q, dirty_d;
    logic            req_q, req_d;
    logic            dirty_evt;
    logic            load;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        winner_d = winner_q;
        hold_d   = '0;
        arrived  = '0;
        case (state_q)
            MENU: begin
                if (menu_seen_q && menu_q && !rc.is_in_menu) state_d = RACE;
            end
            RACE: begin
                for (int i = 0; i < 4; i++) begin
                    if (rc.move[i] && pos_q[i] != TRACK_END) begin
                        pos_d[i]   = pos_q[i] + 8'd1;
                        arrived[i] = (pos_q[i] == TRACK_END - 8'd1);
                    end
                end
                if (|arrived) begin
                    state_d  = FINISH;
                    winner_d = arrived;
                end
            end
            FINISH: begin
                if (hold_q == HOLD_LAST) state_d = RESTART;
                else                     hold_d  = hold_q + 1'b1;
            end
            RESTART: begin
                state_d  = MENU;
                pos_d    = '0;
                winner_d = '0;
            end
            default: state_d = MENU;
        endcase
    end

    // A frame change marks the display dirty; the request is raised from the
    // dirty flag only while no request is outstanding, giving one low cycle between frames.
    assign dirty_evt = (state_d != state_q) || (pos_d != pos_q) || (winner_d != winner_q);
    assign load      = !req_q && dirty_q;
    assign req_d     = load | (req_q & ~rc.refresh_ack);
    assign dirty_d   = dirty_evt | (dirty_q & ~load);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= MENU;
            pos_q        <= '0;
            winner_q     <= '0;
            hold_q       <= '0;
            menu_q       <= 1'b1;
            menu_seen_q  <= 1'b0;
            menu_reset_q <= 1'b0;
            dirty_q      <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            winner_q     <= winner_d;
            hold_q       <= hold_d;
            menu_q       <= rc.is_in_menu;
            // A race may only start after is_in_menu has really been seen high
            // since reset, so a level held low across reset release cannot fake an edge.
            menu_seen_q  <= menu_seen_q | rc.is_in_menu;
            menu_reset_q <= (state_d == RESTART);
            dirty_q      <= dirty_d;
            req_q        <= req_d;
        end
    end

    assign rc.phase       = state_q;
    assign rc.pos         = pos_q;
    assign rc.winner      = winner_q;
    assign rc.menu_reset  = menu_reset_q;
    assign rc.refresh_req = req_q;
endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller with a short track and a short finish hold.
module tb_race_controller;
    localparam int TL   = 3;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    race_controller_if rc ();

    race_controller #(
        .TRACK_LEN             (TL),
        .FINISH_HOLD_CLK_COUNT (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rc    (rc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_race(input string tag);
        rc.is_in_menu = 1'b1;
        step();
        rc.is_in_menu = 1'b0;
        step();
        check(tag, 32'(rc.phase), 32'd1);
    endtask

    initial begin
        reset          = 1'b0;
        rc.is_in_menu  = 1'b1;
        rc.move        = 4'b0000;
        rc.refresh_ack = 1'b1;
        #12;
        check("rst_phase", 32'(rc.phase), 32'd0);
        check("rst_pos", rc.pos, 32'd0);
        check("rst_winner", 32'(rc.winner), 32'd0);
        check("rst_menu_reset", 32'(rc.menu_reset), 32'd0);
        check("rst_req", 32'(rc.refresh_req), 32'd0);
        reset = 1'b1;
        step();
        step();

        // Moves in MENU are ignored and cause no redraw.
        rc.move = 4'b1111;
        step();
        rc.move = 4'b0000;
        check("menu_pos", rc.pos, 32'd0);
        check("menu_phase", 32'(rc.phase), 32'd0);
        step();
        check("menu_req", 32'(rc.refresh_req), 32'd0);

        // Race 1: green runs alone to the line.
        start_race("r1_start");
        rc.move = 4'b0001;
        step();
        check("r1_pos1", rc.pos, 32'h0000_0001);
        check("r1_phase1", 32'(rc.phase), 32'd1);
        step();
        check("r1_pos2", rc.pos, 32'h0000_0002);
        step();
        check("r1_pos3", rc.pos, 32'h0000_0003);
        check("r1_phase_fin", 32'(rc.phase), 32'd2);
        check("r1_winner", 32'(rc.winner), 32'h1);
        rc.move = 4'b1111;
        step();
        rc.move = 4'b0000;
        check("fin_freeze_pos", rc.pos, 32'h0000_0003);
        check("fin_freeze_win", 32'(rc.winner), 32'h1);
        step();
        step();
        check("fin_no_dirty", 32'(rc.refresh_req), 32'd0);
        check("fin_hold_phase", 32'(rc.phase), 32'd2);
        step();
        check("restart_phase", 32'(rc.phase), 32'd3);
        check("restart_pulse", 32'(rc.menu_reset), 32'd1);
        step();
        check("back_menu_phase", 32'(rc.phase), 32'd0);
        check("back_menu_pos", rc.pos, 32'd0);
        check("back_menu_win", 32'(rc.winner), 32'd0);
        check("back_menu_pulse", 32'(rc.menu_reset), 32'd0);

        // Race 2: green and red tie.
        start_race("r2_start");
        rc.move = 4'b0011;
        step();
        check("tie_pos1", rc.pos, 32'h0000_0101);
        step();
        check("tie_pos2", rc.pos, 32'h0000_0202);
        step();
        rc.move = 4'b0000;
        check("tie_pos3", rc.pos, 32'h0000_0303);
        check("tie_winner", 32'(rc.winner), 32'h3);
        check("tie_phase", 32'(rc.phase), 32'd2);
        for (int i = 0; i < HOLD - 1; i++) step();
        check("tie_hold", 32'(rc.phase), 32'd2);
        step();
        check("tie_restart", 32'(rc.phase), 32'd3);
        step();
        check("tie_menu", 32'(rc.phase), 32'd0);
        check("tie_menu_pos", rc.pos, 32'd0);

        // Race 3: refresh handshake with a stalled driver.
        start_race("r3_start");
        step();
        step();
        step();
        check("hs_idle", 32'(rc.refresh_req), 32'd0);
        rc.refresh_ack = 1'b0;
        rc.move        = 4'b0001;
        step();
        rc.move = 4'b0000;
        step();
        check("hs_rise", 32'(rc.refresh_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            rc.move = (i == 3) ? 4'b0010 : 4'b0000;
            step();
            check("hs_hold", 32'(rc.refresh_req), 32'd1);
        end
        rc.move        = 4'b0000;
        rc.refresh_ack = 1'b1;
        step();
        rc.refresh_ack = 1'b0;
        check("hs_drop", 32'(rc.refresh_req), 32'd0);
        step();
        check("hs_reassert", 32'(rc.refresh_req), 32'd1);
        check("hs_pos", rc.pos, 32'h0000_0101);
        rc.move = 4'b0001;
        step();
        rc.move = 4'b0000;
        check("mid_pos", rc.pos, 32'h0000_0102);
        check("mid_req", 32'(rc.refresh_req), 32'd1);

        // Asynchronous reset mid-race and mid-handshake.
        #2;
        rc.is_in_menu = 1'b0;
        reset         = 1'b0;
        #1;
        check("async_phase", 32'(rc.phase), 32'd0);
        check("async_pos", rc.pos, 32'd0);
        check("async_winner", 32'(rc.winner), 32'd0);
        check("async_menu_reset", 32'(rc.menu_reset), 32'd0);
        check("async_req", 32'(rc.refresh_req), 32'd0);
        step();
        step();
        #3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_low", 32'(rc.phase), 32'd0);
        end
        start_race("post_rst_edge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
